// File: rtl/row_uram_arbiter.sv
// Row-level URAM arbiter: round-robin ownership grant over the cores of one row,
// registered URAM port mux, emptied-event broadcast and dirty tracking.
//
// state  | meaning
// IDLE   | no owner; scan requesters starting after the last released core
// GRANT  | grant issued to idx, waiting for the core to lock (or abandon)
// HOLD   | core idx owns the URAM until it drops locked
module row_uram_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int URAM_ADDR_W = 12,
  parameter int DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            i_core_req,
  input  logic [NUM_CORES-1:0]            i_core_locked,
  output logic [NUM_CORES-1:0]            o_core_grant,
  input  logic [NUM_CORES-1:0]            i_core_uram_en,
  input  logic [NUM_CORES*URAM_ADDR_W-1:0] i_core_uram_addr,
  input  logic [NUM_CORES*DATA_W-1:0]     i_core_uram_wr_data,
  input  logic [NUM_CORES-1:0]            i_core_uram_wr_en,
  output logic                            o_uram_en,
  output logic [URAM_ADDR_W-1:0]          o_uram_addr,
  output logic [DATA_W-1:0]               o_uram_wr_data,
  output logic                            o_uram_wr_en,
  input  logic                            i_host_emptied,
  output logic                            o_uram_emptied,
  output logic                            o_uram_dirty,
  output logic                            o_busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       pick, cand;
  logic                   found;
  logic                   active;

  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic                   uram_en_q, uram_en_d;
  logic [URAM_ADDR_W-1:0] uram_addr_q, uram_addr_d;
  logic [DATA_W-1:0]      uram_data_q, uram_data_d;
  logic                   uram_we_q, uram_we_d;
  logic                   emptied_q;
  logic                   dirty_q, dirty_d;

  // First requester strictly after ptr, wrapping; ptr itself is checked last.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_CORES);
      if (!found && i_core_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          idx_d   = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (i_core_locked[idx_q]) begin
          state_d = ST_HOLD;
        end else if (!i_core_req[idx_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!i_core_locked[idx_q]) begin
          state_d = ST_IDLE;
          ptr_d   = idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    if (state_d != ST_IDLE) begin
      grant_d[idx_d] = 1'b1;
    end
  end

  assign active = (state_q != ST_IDLE);

  always_comb begin
    uram_en_d   = 1'b0;
    uram_addr_d = '0;
    uram_data_d = '0;
    uram_we_d   = 1'b0;
    if (active) begin
      uram_en_d   = i_core_uram_en[idx_q];
      uram_addr_d = i_core_uram_addr[idx_q*URAM_ADDR_W +: URAM_ADDR_W];
      uram_data_d = i_core_uram_wr_data[idx_q*DATA_W +: DATA_W];
      uram_we_d   = i_core_uram_wr_en[idx_q];
    end
  end

  // A write reaching the URAM outranks a same-cycle drain notification.
  always_comb begin
    dirty_d = dirty_q;
    if (uram_we_q) begin
      dirty_d = 1'b1;
    end else if (i_host_emptied) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ptr_q       <= IDX_W'(NUM_CORES - 1);
      grant_q     <= '0;
      uram_en_q   <= 1'b0;
      uram_addr_q <= '0;
      uram_data_q <= '0;
      uram_we_q   <= 1'b0;
      emptied_q   <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      uram_en_q   <= uram_en_d;
      uram_addr_q <= uram_addr_d;
      uram_data_q <= uram_data_d;
      uram_we_q   <= uram_we_d;
      emptied_q   <= i_host_emptied;
      dirty_q     <= dirty_d;
    end
  end

  assign o_core_grant   = grant_q;
  assign o_uram_en      = uram_en_q;
  assign o_uram_addr    = uram_addr_q;
  assign o_uram_wr_data = uram_data_q;
  assign o_uram_wr_en   = uram_we_q;
  assign o_uram_emptied = emptied_q;
  assign o_uram_dirty   = dirty_q;
  assign o_busy         = active;

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Bench for row_uram_arbiter: directed scenarios plus randomized traffic
// compared against an owner/pointer reference model.
module tb_row_uram_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, locked, en, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic            host;
  logic [N-1:0]    o_core_grant;
  logic            o_uram_en, o_uram_wr_en, o_uram_emptied, o_uram_dirty, o_busy;
  logic [AW-1:0]   o_uram_addr;
  logic [DW-1:0]   o_uram_wr_data;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the URAM, whether they have locked yet, last released core
  int          m_owner;
  int          m_ptr;
  bit          m_locked_seen;
  logic        m_en, m_we, m_empt, m_dirty;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  row_uram_arbiter #(.NUM_CORES(N), .URAM_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_core_req          (req),
    .i_core_locked       (locked),
    .o_core_grant        (o_core_grant),
    .i_core_uram_en      (en),
    .i_core_uram_addr    (addr),
    .i_core_uram_wr_data (wdata),
    .i_core_uram_wr_en   (we),
    .o_uram_en           (o_uram_en),
    .o_uram_addr         (o_uram_addr),
    .o_uram_wr_data      (o_uram_wr_data),
    .o_uram_wr_en        (o_uram_wr_en),
    .i_host_emptied      (host),
    .o_uram_emptied      (o_uram_emptied),
    .o_uram_dirty        (o_uram_dirty),
    .o_busy              (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_locked_seen = 0;
    m_en = 0; m_we = 0; m_empt = 0; m_dirty = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    bit hit;
    int c;
    m_dirty = m_we ? 1'b1 : (host ? 1'b0 : m_dirty);
    m_empt  = host;
    if (m_owner >= 0) begin
      m_en = en[m_owner]; m_we = we[m_owner];
      m_addr = addr[m_owner*AW +: AW]; m_data = wdata[m_owner*DW +: DW];
    end else begin
      m_en = 0; m_we = 0; m_addr = '0; m_data = '0;
    end
    if (m_owner < 0) begin
      hit = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (!hit && req[c]) begin hit = 1; m_owner = c; m_locked_seen = 0; end
      end
    end else if (!m_locked_seen) begin
      if (locked[m_owner]) m_locked_seen = 1;
      else if (!req[m_owner]) m_owner = -1;
    end else if (!locked[m_owner]) begin
      m_ptr = m_owner; m_owner = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; locked = '0; en = '0; we = '0; addr = '0; wdata = '0; host = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
         o_uram_emptied, o_uram_dirty, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b en=%b addr=%h data=%h we=%b emp=%b dirty=%b busy=%b, required all 0",
               o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
               o_uram_emptied, o_uram_dirty, o_busy);
    end
    step();
    checks++;
    if (o_core_grant !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: grant=%b busy=%b, required 0000/0", o_core_grant, o_busy);
    end
  endtask

  task automatic test_single_req();
    apply_reset();
    req[2] = 1'b1;
    step();                                 // t1
    checks++;
    if (o_core_grant !== 4'b0100 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant_t1: grant=%b busy=%b, required 0100/1", o_core_grant, o_busy);
    end
    step();                                 // t2
    locked[2] = 1'b1;
    step(); step(); step();                 // t3..t5
    checks++;
    if (o_core_grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_hold: grant=%b, required 0100", o_core_grant);
    end
    locked[2] = 1'b0; req[2] = 1'b0;
    step();                                 // t6
    checks++;
    if (o_core_grant !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b busy=%b, required 0000/0", o_core_grant, o_busy);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int hold_cnt, off_cyc, owner;
    logic [N-1:0] prev;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req = '1;
    prev = '0; hold_cnt = 0; off_cyc = 0;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      step();
      checks++;
      if (!$onehot0(o_core_grant) || o_core_grant !== exp_grant()) begin
        errors++;
        $display("FAIL rr_grant_cycle%0d: grant=%b, required %b", cyc, o_core_grant, exp_grant());
      end
      if (o_core_grant == '0 && prev != '0) off_cyc = cyc;
      if (o_core_grant != '0 && prev == '0) begin
        owner = -1;
        for (int k = 0; k < N; k++) if (o_core_grant[k]) owner = k;
        if (order.size() > 0) begin
          checks++;
          if (cyc - off_cyc != 1) begin
            errors++;
            $display("FAIL rr_gap: idle cycles=%0d, required 1", cyc - off_cyc);
          end
        end
        order.push_back(owner);
        locked = o_core_grant;
        hold_cnt = 3;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) locked = '0;
      end
      prev = o_core_grant;
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_timeout: grants seen=%0d, required 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: core=%0d, required %0d", i, order[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_write();
    apply_reset();
    req[1] = 1'b1;
    step();
    checks++;
    if (o_core_grant !== 4'b0010) begin
      errors++;
      $display("FAIL write_grant: grant=%b, required 0010", o_core_grant);
    end
    locked[1] = 1'b1; en[1] = 1'b1; we[1] = 1'b1;
    addr[1*AW +: AW] = 12'h123; wdata[1*DW +: DW] = 32'hDEADBEEF;
    step();
    checks++;
    if (o_uram_en !== 1'b1 || o_uram_addr !== 12'h123 || o_uram_wr_data !== 32'hDEADBEEF ||
        o_uram_wr_en !== 1'b1 || o_uram_dirty !== 1'b0) begin
      errors++;
      $display("FAIL write_mux: en=%b addr=%h data=%h we=%b dirty=%b, required 1/123/deadbeef/1/0",
               o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en, o_uram_dirty);
    end
    en[1] = 1'b0; we[1] = 1'b0;
    step();
    checks++;
    if (o_uram_dirty !== 1'b1 || o_uram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL write_dirty: dirty=%b we=%b, required 1/0", o_uram_dirty, o_uram_wr_en);
    end
  endtask

  task automatic test_locked_ignored();
    apply_reset();
    req[0] = 1'b1;
    step();
    locked[0] = 1'b1; en[0] = 1'b1;
    addr[0*AW +: AW] = 12'h0AA; wdata[0*DW +: DW] = 32'h11111111;
    req[3] = 1'b1; locked[3] = 1'b1; en[3] = 1'b1; we[3] = 1'b1;
    addr[3*AW +: AW] = 12'h3FF; wdata[3*DW +: DW] = 32'h33333333;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_core_grant !== 4'b0001 || o_uram_addr !== 12'h0AA ||
          o_uram_wr_data !== 32'h11111111 || o_uram_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL locked_ignored[%0d]: grant=%b addr=%h data=%h we=%b, required 0001/0aa/11111111/0",
                 i, o_core_grant, o_uram_addr, o_uram_wr_data, o_uram_wr_en);
      end
    end
    checks++;
    if (o_uram_dirty !== 1'b0) begin
      errors++;
      $display("FAIL locked_ignored_dirty: dirty=%b, required 0", o_uram_dirty);
    end
  endtask

  task automatic test_abandon();
    apply_reset();
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    step();
    checks++;
    if (o_core_grant !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abandon_drop: grant=%b busy=%b, required 0000/0", o_core_grant, o_busy);
    end
    req = '1;
    step();
    checks++;
    if (o_core_grant !== 4'b0001) begin
      errors++;
      $display("FAIL abandon_ptr: grant=%b, required 0001", o_core_grant);
    end
  endtask

  task automatic test_emptied();
    apply_reset();
    host = 1'b1;
    step();
    checks++;
    if (o_uram_emptied !== 1'b1 || o_uram_dirty !== 1'b0) begin
      errors++;
      $display("FAIL emptied_pulse: emptied=%b dirty=%b, required 1/0", o_uram_emptied, o_uram_dirty);
    end
    host = 1'b0;
    step();
    checks++;
    if (o_uram_emptied !== 1'b0) begin
      errors++;
      $display("FAIL emptied_width: emptied=%b, required 0", o_uram_emptied);
    end
    req[0] = 1'b1;
    step();
    we[0] = 1'b1; en[0] = 1'b1;
    step();
    we[0] = 1'b0; en[0] = 1'b0; host = 1'b1;
    step();
    checks++;
    if (o_uram_dirty !== 1'b1 || o_uram_emptied !== 1'b1) begin
      errors++;
      $display("FAIL emptied_write_wins: dirty=%b emptied=%b, required 1/1", o_uram_dirty, o_uram_emptied);
    end
    host = 1'b0;
    step();
    host = 1'b1;
    step();
    host = 1'b0;
    checks++;
    if (o_uram_dirty !== 1'b0) begin
      errors++;
      $display("FAIL emptied_clear: dirty=%b, required 0", o_uram_dirty);
    end
  endtask

  task automatic test_reset_hold();
    apply_reset();
    req[1] = 1'b1;
    step();
    locked[1] = 1'b1; en[1] = 1'b1; we[1] = 1'b1;
    addr[1*AW +: AW] = 12'h055; wdata[1*DW +: DW] = 32'hCAFEF00D;
    step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if ({o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
         o_uram_emptied, o_uram_dirty, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_in_hold: grant=%b en=%b addr=%h data=%h we=%b dirty=%b busy=%b, required all 0",
               o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
               o_uram_dirty, o_busy);
    end
    clear_inputs();
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [52:0] act, expv;
    apply_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int k = 0; k < N; k++) begin
        req[k]    = ($urandom_range(0, 9) < 4);
        locked[k] = ($urandom_range(0, 9) < 7);
        en[k]     = $urandom_range(0, 1);
        we[k]     = ($urandom_range(0, 3) == 0);
        addr[k*AW +: AW]  = AW'($urandom);
        wdata[k*DW +: DW] = $urandom;
      end
      host = ($urandom_range(0, 7) == 0);
      step();
      act  = {o_core_grant, o_uram_en, o_uram_addr, o_uram_wr_data, o_uram_wr_en,
              o_uram_emptied, o_uram_dirty, o_busy};
      expv = {exp_grant(), m_en, m_addr, m_data, m_we, m_empt, m_dirty, (m_owner >= 0)};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL random_cycle%0d: outputs=%h, required %h", cyc, act, expv);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_req();
    test_round_robin();
    test_write();
    test_locked_ignored();
    test_abandon();
    test_emptied();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
